uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares one byte-level UART transmitter between NUM_REQ requesters, for example a button-triggered message sender, an RX echo path and a status reporter. Each requester streams a message as bytes over a valid/ready interface and marks the final byte with last. Grants are round-robin and held for the whole message, so messages never interleave on the line. The block also enforces an idle gap between messages and releases a requester that stalls mid-message.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GAP_CYCLES, 234, idle clk cycles inserted after each message's last byte is accepted (0 = no gap; default is one bit time at 27 MHz / 115200)
TIMEOUT_CYCLES, 27000, max consecutive cycles a granted requester may hold req_valid low mid-message before its grant is revoked (must be >= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester end-of-message flag, qualified by req_valid
req_ready  out  NUM_REQ  per-requester accept
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  byte valid to transmitter
tx_ready  in  1  transmitter can accept a byte (high while idle)
grant  out  NUM_REQ  one-hot registered grant; all zero when no requester owns the line
busy  out  1  high in SEND or GAP
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, rr_ptr=0, gap and timeout counters=0, timeout_pulse=0, busy=0. Consequently tx_valid=0, req_ready=0 and tx_data=0.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req_valid is high, select the first set index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant one-hot and go to SEND at the next edge. Arbitration latency is 1 cycle.
  - Grant is issued on req_valid alone; req_last is ignored in IDLE.
  - If no req_valid is high, stay in IDLE.
- SEND:
  - Datapath is combinational from the registered grant: tx_valid = req_valid[g], tx_data = req_data[g], req_ready[g] = tx_ready. req_ready of every non-granted requester stays 0.
  - A transfer happens on a cycle with tx_valid && tx_ready.
  - Transfer with req_last[g]=1: release. Set grant to 0, set rr_ptr = (g+1) mod NUM_REQ, then go to GAP with gap counter = GAP_CYCLES, or go straight to IDLE if GAP_CYCLES=0.
  - Timeout counter: reset to 0 on any cycle where req_valid[g]=1; otherwise increment.
  - When the counter reaches TIMEOUT_CYCLES (checked before tx_ready): release as for last, take the same GAP/IDLE path, and pulse timeout_pulse for 1 cycle.
  - Waiting on tx_ready with valid high never times out.
- GAP: grant=0, all req_ready=0, tx_valid=0. Decrement each cycle; at 0 go to IDLE.
  - With GAP_CYCLES=N, the first possible new grant is N+1 cycles after the release edge.
- Simultaneous events: a last-byte transfer and a timeout cannot coincide, because the timeout requires valid low. New requests arriving in SEND or GAP wait; they are not dropped or queued inside the block.
- A requester that drops valid and raises it again within the timeout keeps its grant.
- Reset mid-message: immediate release. Any partially sent message is abandoned, and the transmitter sees tx_valid fall asynchronously.
- rr_ptr is only updated on release, so a requester that was just served has the lowest priority in the next arbitration.
- Counter widths are $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1).

Test Plan:
1. Single requester: req0 sends "Hi" (0x48, 0x69 with last), tx_ready always 1 -> grant=001 one cycle after valid; tx_data 0x48 then 0x69; grant=0 after the second transfer; busy stays high for GAP_CYCLES more cycles.
2. Contention: req0, req1 and req2 each hold 2-byte messages from cycle 0 -> messages go out in order 0, 1, 2 with no interleaving and a gap of 234 cycles between messages. Re-assert all three -> order 0, 1, 2 again (rr_ptr wrapped to 0).
3. Fairness: req0 continuously re-requests while req2 requests once -> req2 is granted immediately after req0's first message.
4. Backpressure: tx_ready low for 500 cycles while req1 holds valid -> no timeout; the byte transfers on the first cycle tx_ready returns high; req_ready[1] mirrors tx_ready.
5. Stall timeout: req1 sends one byte without last, then drops valid -> timeout_pulse exactly TIMEOUT_CYCLES cycles later; grant=0; a pending req2 is granted after the gap.
6. Reset mid-message: assert rst_n low during byte 2 of req0 -> grant, tx_valid and req_ready go low without a clock edge; after release, req1 is granted first if only req1 is valid.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one byte-wide UART transmitter between NUM_REQ
// requesters. Grants are round-robin and held for a whole message (until a
// byte with last is accepted). After each message the line is held idle for
// GAP_CYCLES. A requester that keeps valid low for TIMEOUT_CYCLES consecutive
// cycles mid-message loses its grant.
//
// Handshake: a byte moves on every cycle where valid and ready are both high.
// Valid must not wait for ready. Ready may depend combinationally on the
// other side's state. Here tx_valid/tx_data follow the granted requester
// combinationally, and req_ready of the granted requester follows tx_ready.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int GAP_CYCLES     = 234,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   IDX_WRAP = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic               timeout_pulse_q, timeout_pulse_d;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W:0]     arb_cand;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               rel;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (arb_cand >= IDX_WRAP) begin
        arb_cand = arb_cand - IDX_WRAP;
      end
      if (!arb_found && req_valid[arb_cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IDX_W-1:0];
      end
    end
  end

  // Mux the granted requester's byte stream and route tx_ready back to it.
  always_comb begin
    sel_valid = req_valid[gnt_idx_q];
    sel_data  = req_data[8*gnt_idx_q +: 8];
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == S_SEND) begin
      tx_valid             = sel_valid;
      tx_data              = sel_data;
      req_ready[gnt_idx_q] = tx_ready;
    end
  end

  // Next-state logic: arbitration, message release, gap and stall timers.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gnt_idx_d       = gnt_idx_q;
    rr_ptr_d        = rr_ptr_q;
    gap_cnt_d       = gap_cnt_q;
    to_cnt_d        = to_cnt_q;
    timeout_pulse_d = 1'b0;
    rel             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d   = S_SEND;
          gnt_idx_d = arb_idx;
          grant_d   = NUM_REQ'(1) << arb_idx;
          to_cnt_d  = '0;
        end
      end
      S_SEND: begin
        // A stalled requester only accrues time while its valid is low,
        // so a last-byte transfer and a timeout can never coincide.
        if (sel_valid) begin
          to_cnt_d = '0;
          if (tx_ready && req_last[gnt_idx_q]) begin
            rel = 1'b1;
          end
        end else if (to_cnt_q == TMO_LAST) begin
          rel             = 1'b1;
          timeout_pulse_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CNT_ONE;
        end
        if (rel) begin
          grant_d  = '0;
          to_cnt_d = '0;
          rr_ptr_d = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        // Leaving on the count-to-zero edge makes the next grant land
        // exactly GAP_CYCLES+1 edges after the release edge.
        gap_cnt_d = gap_cnt_q - CNT_ONE;
        if (gap_cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and counter registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      gnt_idx_q       <= '0;
      rr_ptr_q        <= '0;
      gap_cnt_q       <= '0;
      to_cnt_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      gnt_idx_q       <= gnt_idx_d;
      rr_ptr_q        <= rr_ptr_d;
      gap_cnt_q       <= gap_cnt_d;
      to_cnt_q        <= to_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios followed by randomized
// traffic, all checked every cycle against a message-level model of the
// scheduler (owner, remaining gap, stall run length, round-robin pointer).
module tb_uart_tx_scheduler;

  localparam int N   = 3;
  localparam int GAP = 234;
  localparam int TMO = 600;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_pulse;

  uart_tx_scheduler #(
    .NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requester sources: {last, data}
  logic [8:0] src_q [N][$];
  int stall_left [N];
  int stall_prob      = 0;   // percent per cycle, short stall
  int long_stall_prob = 0;   // per mille per cycle, stall long enough to time out
  int ready_mode      = 1;   // 0 low, 1 high, 2 random
  int ready_pct       = 70;

  // reference model
  int m_owner = -1;
  int m_gap   = 0;
  int m_low   = 0;
  int m_ptr   = 0;
  bit m_pulse = 1'b0;
  int grant_log [$];
  int grant_cyc [$];
  int pulse_cyc = -1;

  // scoreboard
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget exhausted (cycle %0d)", name, cyc);
  endtask

  task automatic push_msg(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      src_q[r].push_back({(k == len - 1), 8'($urandom)});
    end
  endtask

  task automatic m_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_gap   = GAP;
    m_low   = 0;
  endtask

  // Advance the model across one clock edge using the inputs held during it.
  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] l,
                            input logic [8*N-1:0] d, input logic rdy);
    m_pulse = 1'b0;
    if (m_owner >= 0) begin
      if (v[m_owner]) begin
        m_low = 0;
        if (rdy) begin
          exp_q.push_back(d[8*m_owner +: 8]);
          if (l[m_owner]) m_release();
        end
      end else begin
        m_low++;
        if (m_low == TMO) begin
          m_release();
          m_pulse   = 1'b1;
          pulse_cyc = cyc + 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (v != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (v[idx]) begin
          m_owner = idx;
          break;
        end
      end
      m_low = 0;
      grant_log.push_back(m_owner);
      grant_cyc.push_back(cyc + 1);
    end
  endtask

  // driver: compute this cycle's requester and transmitter inputs
  task automatic drive_inputs(output logic [N-1:0] v, output logic [N-1:0] l,
                              output logic [8*N-1:0] d, output logic rdy);
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d[8*i +: 8] = 8'($urandom);
      if (src_q[i].size() > 0 && stall_left[i] == 0) begin
        if ($urandom_range(0, 99) < stall_prob) stall_left[i] = $urandom_range(1, 8);
        else if ($urandom_range(0, 999) < long_stall_prob) stall_left[i] = TMO + $urandom_range(0, 40);
      end
      if (stall_left[i] > 0) begin
        stall_left[i]--;
        l[i] = 1'($urandom);
      end else if (src_q[i].size() > 0) begin
        v[i]        = 1'b1;
        d[8*i +: 8] = src_q[i][0][7:0];
        l[i]        = src_q[i][0][8];
      end else begin
        l[i] = 1'($urandom);
      end
    end
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(0, 99) < ready_pct);
    endcase
  endtask

  // One cycle: drive at negedge, compare outputs against the model, step it.
  task automatic cycle();
    logic [N-1:0]   v, l, e_gnt, e_rdy;
    logic [8*N-1:0] d;
    logic           rdy, e_tv, e_busy;
    @(negedge clk);
    cyc++;
    drive_inputs(v, l, d, rdy);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    tx_ready  = rdy;
    #1;
    e_gnt  = '0;
    e_rdy  = '0;
    e_tv   = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_rdy[m_owner] = rdy;
      e_tv           = v[m_owner];
    end
    e_busy = (m_owner >= 0) || (m_gap > 0);
    chk("grant", grant, e_gnt);
    chk("busy", busy, e_busy);
    chk("tx_valid", tx_valid, e_tv);
    chk("req_ready", req_ready, e_rdy);
    chk("timeout_pulse", timeout_pulse, m_pulse);
    if (e_tv) chk("tx_data", tx_data, d[8*m_owner +: 8]);
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    end
    model_step(v, l, d, rdy);
  endtask

  function automatic bit model_active();
    bit a;
    a = (m_owner >= 0) || (m_gap > 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) a = 1'b1;
    return a;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (model_active() && n < budget) begin
      cycle();
      n++;
    end
    if (model_active()) bound_fail(name);
  endtask

  // main sequence
  initial begin
    int t0, n, g0, ta, p, tp_count;
    for (int i = 0; i < N; i++) stall_left[i] = 0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // contention: all three from the same cycle, twice
    for (int round = 0; round < 2; round++) begin
      g0 = grant_log.size();
      for (int r = 0; r < N; r++) push_msg(r, 2);
      run_until_idle(3000, "t2_drain");
      if (grant_log.size() < g0 + 3) bound_fail("t2_grants");
      else begin
        chk("t2_order_a", grant_log[g0], 0);
        chk("t2_order_b", grant_log[g0+1], 1);
        chk("t2_order_c", grant_log[g0+2], 2);
        chk("t2_spacing_ab", grant_cyc[g0+1] - grant_cyc[g0], 237);
        chk("t2_spacing_bc", grant_cyc[g0+2] - grant_cyc[g0+1], 237);
      end
    end

    // single requester sends "Hi"
    src_q[0].push_back({1'b0, 8'h48});
    src_q[0].push_back({1'b1, 8'h69});
    cycle();
    t0 = cyc;
    cycle();
    chk("t1_grant", grant, 3'b001);
    chk("t1_byte0", tx_data, 8'h48);
    chk("t1_grant_cycle", grant_cyc[grant_cyc.size()-1], t0 + 1);
    cycle();
    chk("t1_byte1", tx_data, 8'h69);
    cycle();
    chk("t1_release", grant, 0);
    chk("t1_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      cycle();
    end
    chk("t1_gap_len", n, 234);

    // one message from req2 returns the pointer to 0 before the fairness case
    push_msg(2, 1);
    run_until_idle(1000, "prime_drain");

    // fairness: req0 keeps re-requesting, req2 asks once
    g0 = grant_log.size();
    push_msg(0, 2);
    push_msg(2, 2);
    n = 0;
    while (grant_log.size() < g0 + 3 && n < 3000) begin
      if (src_q[0].size() == 0) push_msg(0, 2);
      cycle();
      n++;
    end
    if (grant_log.size() < g0 + 3) bound_fail("t3_grants");
    else begin
      chk("t3_first", grant_log[g0], 0);
      chk("t3_second", grant_log[g0+1], 2);
      chk("t3_third", grant_log[g0+2], 0);
    end
    run_until_idle(2000, "t3_drain");

    // backpressure longer than the timeout with valid held high
    src_q[1].push_back({1'b1, 8'hC3});
    ready_mode = 0;
    cycle();
    tp_count = 0;
    repeat (700) begin
      cycle();
      if (timeout_pulse === 1'b1) tp_count++;
    end
    chk("t4_no_timeout", tp_count, 0);
    chk("t4_grant_held", grant, 3'b010);
    ready_mode = 1;
    cycle();
    chk("t4_ready", req_ready, 3'b010);
    chk("t4_data", tx_data, 8'hC3);
    cycle();
    chk("t4_release", grant, 0);
    run_until_idle(1000, "t4_drain");

    // stall timeout on req1 with req2 pending
    src_q[1].push_back({1'b0, 8'hA5});
    src_q[1].push_back({1'b1, 8'h5A});
    cycle();
    push_msg(2, 2);
    ta = -1;
    n  = 0;
    while (ta < 0 && n < 50) begin
      cycle();
      n++;
      if (src_q[1].size() == 1) begin
        stall_left[1] = TMO + 500;
        ta = cyc;
      end
    end
    if (ta < 0) bound_fail("t5_first_byte");
    else begin
      n = 0;
      while (timeout_pulse !== 1'b1 && n < 1000) begin
        cycle();
        n++;
      end
      if (timeout_pulse !== 1'b1) bound_fail("t5_pulse");
      else begin
        p = cyc;
        chk("t5_latency", p - ta, TMO + 1);
        chk("t5_grant_cleared", grant, 0);
        chk("t5_model_pulse", pulse_cyc, p);
        n = 0;
        while (grant !== 3'b100 && n < 1000) begin
          cycle();
          n++;
        end
        chk("t5_next_owner", grant_log[grant_log.size()-1], 2);
        chk("t5_regrant_cycle", grant_cyc[grant_cyc.size()-1], p + GAP + 1);
      end
    end
    run_until_idle(5000, "t5_drain");

    // reset during the second byte of a req0 message
    push_msg(0, 3);
    n = 0;
    while (!(m_owner == 0 && src_q[0].size() == 2) && n < 50) begin
      cycle();
      n++;
    end
    @(negedge clk);
    req_valid = 3'b001;
    req_last  = 3'b000;
    req_data  = {16'h0000, src_q[0][0][7:0]};
    tx_ready  = 1'b1;
    #1;
    chk("t6_pre_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_busy", busy, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      stall_left[i] = 0;
    end
    m_owner   = -1;
    m_gap     = 0;
    m_low     = 0;
    m_ptr     = 0;
    m_pulse   = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_msg(1, 1);
    cycle();
    cycle();
    chk("t6_first_grant", grant, 3'b010);
    chk("t6_model_owner", grant_log[grant_log.size()-1], 1);
    run_until_idle(1000, "t6_drain");

    // randomized traffic with stalls, timeouts and transmitter backpressure
    stall_prob      = 4;
    long_stall_prob = 2;
    ready_mode      = 2;
    for (int c = 0; c < 20000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (src_q[r].size() == 0 && $urandom_range(0, 99) < 3) push_msg(r, $urandom_range(1, 5));
      end
      cycle();
    end
    stall_prob      = 0;
    long_stall_prob = 0;
    run_until_idle(20000, "rand_drain");

    // scoreboard: transmitted stream against the model's expected stream
    chk("sb_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk("sb_byte", got_q.pop_front(), exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
